// File: rtl/morra_pkg.sv
// Shared codes, FSM state type and the win relation for the Morra Cinese referee.
package morra_pkg;

  // Move encodings as they arrive from the player front end
  localparam logic [1:0] MV_NONE     = 2'b00;
  localparam logic [1:0] MV_ROCK     = 2'b01;
  localparam logic [1:0] MV_PAPER    = 2'b10;
  localparam logic [1:0] MV_SCISSORS = 2'b11;

  // Per-round result codes; R_P1/R_P2 double as the winner tag in the win memory
  localparam logic [1:0] R_VOID = 2'b00;
  localparam logic [1:0] R_P1   = 2'b01;
  localparam logic [1:0] R_P2   = 2'b10;
  localparam logic [1:0] R_DRAW = 2'b11;

  // Match result codes
  localparam logic [1:0] G_RUN  = 2'b00;
  localparam logic [1:0] G_P1   = 2'b01;
  localparam logic [1:0] G_P2   = 2'b10;
  localparam logic [1:0] G_DRAW = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_END  = 2'b10
  } state_e;

  // True when move a defeats move b (rock > scissors > paper > rock)
  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    return ((a == MV_ROCK)     && (b == MV_SCISSORS)) ||
           ((a == MV_PAPER)    && (b == MV_ROCK))     ||
           ((a == MV_SCISSORS) && (b == MV_PAPER));
  endfunction

endpackage

// File: rtl/morra_round_judge.sv
// Combinational judge for one move pair, including the repeat-ban check
// against the remembered winner and winning move.
module morra_round_judge
  import morra_pkg::*;
#(
  parameter int BAN_REPEAT = 1
) (
  input  logic [1:0] p1_i,
  input  logic [1:0] p2_i,
  input  logic [1:0] mem_who_i,
  input  logic [1:0] mem_move_i,
  output logic [1:0] round_o
);

  logic banned;

  // A remembered winner replaying the move that just won makes the round void
  always_comb begin
    banned = 1'b0;
    if (BAN_REPEAT != 0) begin
      banned = ((mem_who_i == R_P1) && (p1_i == mem_move_i)) ||
               ((mem_who_i == R_P2) && (p2_i == mem_move_i));
    end
  end

  // Missing moves and banned repeats are void; otherwise apply the win relation
  always_comb begin
    round_o = R_VOID;
    if ((p1_i == MV_NONE) || (p2_i == MV_NONE) || banned) begin
      round_o = R_VOID;
    end else if (p1_i == p2_i) begin
      round_o = R_DRAW;
    end else if (beats(p1_i, p2_i)) begin
      round_o = R_P1;
    end else begin
      round_o = R_P2;
    end
  end

endmodule

// File: rtl/morra_cinese_param.sv
// Parametrised Morra Cinese referee: runs the match FSM, judges one move pair
// per cycle, keeps scores and the signed advantage, and declares the result.
module morra_cinese_param
  import morra_pkg::*;
#(
  parameter int MARGIN      = 2,
  parameter int BASE_ROUNDS = 4,
  parameter int CFG_W       = 4,
  parameter int BAN_REPEAT  = 1,
  localparam int RW         = $clog2(BASE_ROUNDS + 2**CFG_W) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CFG_W-1:0] cfg_i,
  input  logic [1:0]       p1_i,
  input  logic [1:0]       p2_i,
  input  logic             valid_i,
  output logic [1:0]       round_o,
  output logic             round_valid_o,
  output logic [1:0]       game_o,
  output logic             done_o,
  output logic [RW-1:0]    score1_o,
  output logic [RW-1:0]    score2_o
);

  // Advantage is kept as RW+1 bit two's complement so it spans +/- any score
  localparam logic [RW-1:0] ONE_RW     = RW'(1);
  localparam logic [RW:0]   ONE_ADV    = (RW+1)'(1);
  localparam logic [RW:0]   MARGIN_POS = (RW+1)'(MARGIN);
  localparam logic [RW:0]   MARGIN_NEG = -MARGIN_POS;

  state_e        state_q, state_d;
  logic [RW-1:0] toPlay_q, toPlay_d;
  logic [RW-1:0] played_q, played_d;
  logic [RW:0]   adv_q, adv_d;
  logic [RW-1:0] score1_q, score1_d;
  logic [RW-1:0] score2_q, score2_d;
  logic [1:0]    memWho_q, memWho_d;
  logic [1:0]    memMove_q, memMove_d;
  logic [1:0]    round_q, round_d;
  logic          roundValid_q, roundValid_d;
  logic [1:0]    game_q, game_d;

  logic [1:0]    judgeRound;
  logic [RW:0]   advNext;
  logic [RW-1:0] playedNext;

  morra_round_judge #(
    .BAN_REPEAT(BAN_REPEAT)
  ) u_judge (
    .p1_i      (p1_i),
    .p2_i      (p2_i),
    .mem_who_i (memWho_q),
    .mem_move_i(memMove_q),
    .round_o   (judgeRound)
  );

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      toPlay_q     <= '0;
      played_q     <= '0;
      adv_q        <= '0;
      score1_q     <= '0;
      score2_q     <= '0;
      memWho_q     <= R_VOID;
      memMove_q    <= MV_NONE;
      round_q      <= R_VOID;
      roundValid_q <= 1'b0;
      game_q       <= G_RUN;
    end else begin
      state_q      <= state_d;
      toPlay_q     <= toPlay_d;
      played_q     <= played_d;
      adv_q        <= adv_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      memWho_q     <= memWho_d;
      memMove_q    <= memMove_d;
      round_q      <= round_d;
      roundValid_q <= roundValid_d;
      game_q       <= game_d;
    end
  end

  // Next state: START wins over a same-cycle move; otherwise judge in PLAY only
  always_comb begin
    state_d      = state_q;
    toPlay_d     = toPlay_q;
    played_d     = played_q;
    adv_d        = adv_q;
    score1_d     = score1_q;
    score2_d     = score2_q;
    memWho_d     = memWho_q;
    memMove_d    = memMove_q;
    round_d      = round_q;
    roundValid_d = 1'b0;
    game_d       = game_q;
    advNext      = adv_q;
    playedNext   = played_q;

    if (start_i) begin
      state_d   = ST_PLAY;
      toPlay_d  = RW'(BASE_ROUNDS) + RW'(cfg_i);
      played_d  = '0;
      adv_d     = '0;
      score1_d  = '0;
      score2_d  = '0;
      memWho_d  = R_VOID;
      memMove_d = MV_NONE;
      round_d   = R_VOID;
      game_d    = G_RUN;
    end else if ((state_q == ST_PLAY) && valid_i) begin
      roundValid_d = 1'b1;
      round_d      = judgeRound;
      playedNext   = played_q + ONE_RW;
      unique case (judgeRound)
        R_P1: begin
          score1_d  = score1_q + ONE_RW;
          advNext   = adv_q + ONE_ADV;
          memWho_d  = R_P1;
          memMove_d = p1_i;
        end
        R_P2: begin
          score2_d  = score2_q + ONE_RW;
          advNext   = adv_q - ONE_ADV;
          memWho_d  = R_P2;
          memMove_d = p2_i;
        end
        R_DRAW: begin
          memWho_d  = R_VOID;
          memMove_d = MV_NONE;
        end
        default: begin
          playedNext = played_q;
        end
      endcase
      adv_d    = advNext;
      played_d = playedNext;

      if ((judgeRound != R_VOID) &&
          ((advNext == MARGIN_POS) || (advNext == MARGIN_NEG) ||
           (playedNext == toPlay_q))) begin
        state_d = ST_END;
        if (advNext == '0) begin
          game_d = G_DRAW;
        end else if (advNext[RW]) begin
          game_d = G_P2;
        end else begin
          game_d = G_P1;
        end
      end
    end
  end

  assign round_o       = round_q;
  assign round_valid_o = roundValid_q;
  assign game_o        = game_q;
  assign done_o        = (state_q == ST_END);
  assign score1_o      = score1_q;
  assign score2_o      = score2_q;

endmodule

// File: tb/tb_morra_cinese_param.sv
// Directed bench for the Morra Cinese referee: one instance with defaults and
// one with MARGIN=3, BASE_ROUNDS=5 and the repeat ban disabled.
module tb_morra_cinese_param;

  localparam int RW = 6;

  logic          clk;
  logic          rst;
  logic          start;
  logic [3:0]    cfg;
  logic [1:0]    p1;
  logic [1:0]    p2;
  logic          valid;

  logic [1:0]    roundA, gameA;
  logic          roundValidA, doneA;
  logic [RW-1:0] score1A, score2A;

  logic [1:0]    roundB, gameB;
  logic          roundValidB, doneB;
  logic [RW-1:0] score1B, score2B;

  int checks;
  int errors;

  morra_cinese_param dutA (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .cfg_i        (cfg),
    .p1_i         (p1),
    .p2_i         (p2),
    .valid_i      (valid),
    .round_o      (roundA),
    .round_valid_o(roundValidA),
    .game_o       (gameA),
    .done_o       (doneA),
    .score1_o     (score1A),
    .score2_o     (score2A)
  );

  morra_cinese_param #(
    .MARGIN     (3),
    .BASE_ROUNDS(5),
    .CFG_W      (4),
    .BAN_REPEAT (0)
  ) dutB (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .cfg_i        (cfg),
    .p1_i         (p1),
    .p2_i         (p2),
    .valid_i      (valid),
    .round_o      (roundB),
    .round_valid_o(roundValidB),
    .game_o       (gameB),
    .done_o       (doneB),
    .score1_o     (score1B),
    .score2_o     (score2B)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if the observed value differs
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs before the edge, then sample 1 ns after it
  task automatic applyStimulus(input logic r, input logic s, input logic [3:0] c,
                               input logic [1:0] a, input logic [1:0] b, input logic v);
    @(negedge clk);
    rst   = r;
    start = s;
    cfg   = c;
    p1    = a;
    p2    = b;
    valid = v;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    valid = 1'b0;
  endtask

  // Compare every output of the default instance
  task automatic expectA(input string tag, input logic [1:0] rnd, input logic rv,
                         input logic [1:0] gm, input logic dn,
                         input int s1, input int s2);
    checkOutput({tag, ".round"},  32'(roundA),      32'(rnd));
    checkOutput({tag, ".rvalid"}, 32'(roundValidA), 32'(rv));
    checkOutput({tag, ".game"},   32'(gameA),       32'(gm));
    checkOutput({tag, ".done"},   32'(doneA),       32'(dn));
    checkOutput({tag, ".score1"}, 32'(score1A),     32'(s1));
    checkOutput({tag, ".score2"}, 32'(score2A),     32'(s2));
  endtask

  // Compare every output of the MARGIN=3 instance
  task automatic expectB(input string tag, input logic [1:0] rnd, input logic rv,
                         input logic [1:0] gm, input logic dn,
                         input int s1, input int s2);
    checkOutput({tag, ".round"},  32'(roundB),      32'(rnd));
    checkOutput({tag, ".rvalid"}, 32'(roundValidB), 32'(rv));
    checkOutput({tag, ".game"},   32'(gameB),       32'(gm));
    checkOutput({tag, ".done"},   32'(doneB),       32'(dn));
    checkOutput({tag, ".score1"}, 32'(score1B),     32'(s1));
    checkOutput({tag, ".score2"}, 32'(score2B),     32'(s2));
  endtask

  // Directed scenarios; moves: 01 rock, 10 paper, 11 scissors
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; start = 1'b0; cfg = 4'd0; p1 = 2'b00; p2 = 2'b00; valid = 1'b0;

    // Reset, then P1 wins twice with different moves: margin 2 reached
    applyStimulus(1, 0, 0, 2'b00, 2'b00, 0);
    expectA("rst", 2'b00, 0, 2'b00, 0, 0, 0);
    applyStimulus(0, 1, 0, 2'b00, 2'b00, 0);
    expectA("t1.start", 2'b00, 0, 2'b00, 0, 0, 0);
    applyStimulus(0, 0, 0, 2'b01, 2'b11, 1);
    expectA("t1.r1", 2'b01, 1, 2'b00, 0, 1, 0);
    applyStimulus(0, 0, 0, 2'b10, 2'b01, 1);
    expectA("t1.r2", 2'b01, 1, 2'b01, 1, 2, 0);
    applyStimulus(0, 0, 0, 2'b01, 2'b11, 1);
    expectA("t1.endIgnore", 2'b01, 0, 2'b01, 1, 2, 0);

    // CFG=1: banned repeat is void and does not move the advantage
    applyStimulus(0, 1, 4'd1, 2'b00, 2'b00, 0);
    expectA("t2.start", 2'b00, 0, 2'b00, 0, 0, 0);
    applyStimulus(0, 0, 0, 2'b01, 2'b11, 1);
    expectA("t2.r1", 2'b01, 1, 2'b00, 0, 1, 0);
    applyStimulus(0, 0, 0, 2'b01, 2'b11, 1);
    expectA("t2.ban", 2'b00, 1, 2'b00, 0, 1, 0);
    applyStimulus(0, 0, 0, 2'b00, 2'b00, 0);
    expectA("t2.hold", 2'b00, 0, 2'b00, 0, 1, 0);
    applyStimulus(0, 0, 0, 2'b10, 2'b01, 1);
    expectA("t2.r3", 2'b01, 1, 2'b01, 1, 2, 0);

    // Win, loss, two draws: budget of 4 rounds ends in a drawn match
    applyStimulus(0, 1, 0, 2'b00, 2'b00, 0);
    applyStimulus(0, 0, 0, 2'b01, 2'b11, 1);
    expectA("t3.r1", 2'b01, 1, 2'b00, 0, 1, 0);
    applyStimulus(0, 0, 0, 2'b11, 2'b01, 1);
    expectA("t3.r2", 2'b10, 1, 2'b00, 0, 1, 1);
    applyStimulus(0, 0, 0, 2'b10, 2'b10, 1);
    expectA("t3.r3", 2'b11, 1, 2'b00, 0, 1, 1);
    applyStimulus(0, 0, 0, 2'b10, 2'b10, 1);
    expectA("t3.r4", 2'b11, 1, 2'b11, 1, 1, 1);

    // Missing moves give void pulses that never end the match
    applyStimulus(0, 1, 0, 2'b00, 2'b00, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 2'b01, 2'b00, 1);
      expectA($sformatf("t4.void%0d", i), 2'b00, 1, 2'b00, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 2'b11, 2'b10, 1);
    expectA("t4.win", 2'b01, 1, 2'b00, 0, 1, 0);

    // START with VALID discards the move; RST mid-match returns to IDLE
    applyStimulus(0, 1, 0, 2'b00, 2'b00, 0);
    applyStimulus(0, 0, 0, 2'b01, 2'b11, 1);
    expectA("t5.r1", 2'b01, 1, 2'b00, 0, 1, 0);
    applyStimulus(0, 1, 0, 2'b01, 2'b11, 1);
    expectA("t5.restart", 2'b00, 0, 2'b00, 0, 0, 0);
    applyStimulus(0, 0, 0, 2'b01, 2'b11, 1);
    expectA("t5.afterRestart", 2'b01, 1, 2'b00, 0, 1, 0);
    applyStimulus(1, 1, 0, 2'b10, 2'b01, 1);
    expectA("t5.rst", 2'b00, 0, 2'b00, 0, 0, 0);
    applyStimulus(0, 0, 0, 2'b01, 2'b11, 1);
    expectA("t5.idleIgnore", 2'b00, 0, 2'b00, 0, 0, 0);

    // MARGIN=3 instance without ban: same winning move three times ends the match
    applyStimulus(0, 1, 0, 2'b00, 2'b00, 0);
    applyStimulus(0, 0, 0, 2'b01, 2'b11, 1);
    expectB("t6.r1", 2'b01, 1, 2'b00, 0, 1, 0);
    applyStimulus(0, 0, 0, 2'b01, 2'b11, 1);
    expectB("t6.r2", 2'b01, 1, 2'b00, 0, 2, 0);
    applyStimulus(0, 0, 0, 2'b01, 2'b11, 1);
    expectB("t6.r3", 2'b01, 1, 2'b01, 1, 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/morra_cinese_param.md
# morra_cinese_param

Parametrised successor of the two-player Morra Cinese (rock-paper-scissors) referee. Each accepted move pair is judged with the repeat-ban rule, and the block tracks per-player scores and the signed advantage. It declares the match when the advantage reaches MARGIN or the configured round budget is used up. It sits between the player-input front end and the display/score logic, replacing the fixed 4+N-round, margin-2 referee.

## Interface
- MARGIN, default 2: absolute advantage that ends the match early; range 1..BASE_ROUNDS.
- BASE_ROUNDS, default 4: rounds always granted.
- CFG_W, default 4: width of CFG. Derived RW = $clog2(BASE_ROUNDS + 2**CFG_W) + 1.
- BAN_REPEAT, default 1: 1 enables the repeat-ban rule, 0 disables it.
- clk  in  1  single clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  sampled each edge; begins a new match.
- CFG  in  CFG_W  extra rounds; sampled only when START=1.
- P1, P2  in  2 each  moves: 00 none, 01 rock, 10 paper, 11 scissors.
- VALID  in  1  move pair is present this cycle.
- ROUND  out  2  last round result: 00 void, 01 P1 wins, 10 P2 wins, 11 draw.
- ROUND_VALID  out  1  one-cycle pulse when ROUND updates.
- GAME  out  2  match result: 00 in progress/idle, 01 P1, 10 P2, 11 draw.
- DONE  out  1  high while in END.
- SCORE1, SCORE2  out  RW each  rounds won per player.

## Operation
- FSM states: IDLE, PLAY, END.
  - IDLE to PLAY on START.
  - PLAY to END on the decisive round.
  - END to PLAY on START.
  - START in PLAY restarts the match.
- START (any state): TO_PLAY = BASE_ROUNDS + CFG (RW-bit, no overflow by construction).
  - PLAYED, ADV (signed RW+1 bits), scores, win memory, ROUND and GAME are cleared.
- Judge runs in PLAY only, when VALID=1. Win relation: 01 beats 11, 10 beats 01, 11 beats 10; equal moves draw.
- Void round: either move is 00, or (BAN_REPEAT=1) the previous winner repeats their winning move.
  - Void does not increment PLAYED and leaves the win memory unchanged.
- Win: winner's score +1; ADV +1 for P1 or -1 for P2; PLAYED +1; memory = {winner, move}.
- Draw: PLAYED +1; memory cleared, so no ban applies next round.
- Match ends after a round in which |ADV| == MARGIN or PLAYED == TO_PLAY.
  - GAME = 01 if ADV > 0, 10 if ADV < 0, 11 if ADV == 0.
- VALID is ignored in IDLE and END. A void round never ends the match.

## Timing
- Reset values: state IDLE; ROUND 00; ROUND_VALID 0; GAME 00; DONE 0; SCORE1/2 0; ADV, PLAYED, TO_PLAY 0; memory cleared.
- All outputs are registered. A move accepted at edge k drives ROUND, ROUND_VALID and the scores after edge k.
  - If that round is decisive, GAME and DONE update at the same edge as the final ROUND (latency 1).
- Back-to-back VALID is allowed: one round judged per cycle, no stall.
- RST has priority over START. START has priority over VALID in the same cycle; that move is discarded.
- RST mid-match: everything returns to reset values at that edge.
- START mid-match: clears outputs at that edge; the first new round can be judged on the next edge.
- ROUND holds its value between pulses. GAME and scores hold through END until START or RST.

## Structure
- Package morra_pkg holds:
  - move codes (MV_NONE, MV_ROCK, MV_PAPER, MV_SCISSORS);
  - ROUND codes (R_VOID, R_P1, R_P2, R_DRAW);
  - GAME codes (G_RUN, G_P1, G_P2, G_DRAW);
  - the FSM state enum;
  - function beats(a, b).
- Sub-module morra_round_judge: combinational. Inputs P1, P2, memory, BAN_REPEAT; output round code. The top level holds the FSM, counters and registers.

## Test plan
- RST, then START with CFG=0, then P1 wins twice (01/11, 10/01) → ROUND 01 twice, SCORE1=2, GAME=01 and DONE=1 after the 2nd round's edge.
- START CFG=1, defaults: P1 wins with 01/11, then P1 replays 01 vs 11 → ROUND=00 (void), PLAYED unchanged, ADV stays +1.
- START CFG=0: win P1, win P2, draw, draw → after round 4, GAME=11, SCORE1=SCORE2=1.
- START CFG=0: P2=00 on three VALID cycles → three void pulses, DONE stays 0; then 11/10 → ROUND=01.
- During PLAY: assert START and VALID together → move ignored, scores 0. Then assert RST mid-match → all outputs zero and state IDLE.
- MARGIN=3, BASE_ROUNDS=5: P1 wins three in a row → GAME=01 after the 3rd round. BAN_REPEAT=0: repeated winning move is judged normally.
